// File: rtl/arp_pkg.sv
// arp_pkg: shared types and sizing for the arpeggiator scheduler.
package arp_pkg;
  localparam int NUM_VOICES = 8;
  localparam int IDX_W = $clog2(NUM_VOICES);
  typedef enum logic [1:0] {IDLE, GAP, PLAY} state_e;
  typedef enum logic {UP, DOWN} dir_e;
endpackage

// File: rtl/arp_next_sel.sv
// arp_next_sel: picks the next held voice after cur, in ascending-wrap or ping-pong order.
module arp_next_sel
  import arp_pkg::*;
#(
  parameter int NV = arp_pkg::NUM_VOICES,
  parameter int IW = $clog2(NV)
) (
  input  logic [NV-1:0] held_i,
  input  logic [IW-1:0] cur_i,
  input  dir_e          dir_i,
  input  logic          pingpong_i,
  output logic [IW-1:0] nxt_o,
  output dir_e          dir_o,
  output logic          found_o
);
  logic [IW-1:0] up_idx, dn_idx, lo_idx, fwd_idx, bwd_idx;
  logic          up_ok, dn_ok, fwd_ok, bwd_ok;
  always_comb begin
    up_idx = '0;
    up_ok  = 1'b0;
    dn_idx = '0;
    dn_ok  = 1'b0;
    lo_idx = '0;
    for (int i = NV - 1; i >= 0; i--) begin
      if (held_i[i] && IW'(i) > cur_i) begin
        up_idx = IW'(i);
        up_ok  = 1'b1;
      end
      if (held_i[i]) lo_idx = IW'(i);
    end
    for (int i = 0; i < NV; i++) begin
      if (held_i[i] && IW'(i) < cur_i) begin
        dn_idx = IW'(i);
        dn_ok  = 1'b1;
      end
    end
    fwd_ok  = dir_i == UP ? up_ok : dn_ok;
    fwd_idx = dir_i == UP ? up_idx : dn_idx;
    bwd_ok  = dir_i == UP ? dn_ok : up_ok;
    bwd_idx = dir_i == UP ? dn_idx : up_idx;
    found_o = |held_i;
    // With no other held key the current index repeats and direction is kept.
    nxt_o = !pingpong_i ? (up_ok ? up_idx : lo_idx) :
            fwd_ok ? fwd_idx : bwd_ok ? bwd_idx : cur_i;
    dir_o = !pingpong_i ? UP :
            (!fwd_ok && bwd_ok) ? (dir_i == UP ? DOWN : UP) : dir_i;
  end
endmodule

// File: rtl/arp_scheduler.sv
// arp_scheduler: passes held keys through, or arpeggiates them one voice at a time
// with a one-cycle gate gap at every step so envelopes retrigger.
module arp_scheduler
  import arp_pkg::*;
#(
  parameter int NUM_VOICES = arp_pkg::NUM_VOICES,
  parameter int TICK_DIV   = 50000,
  parameter int IW         = $clog2(NUM_VOICES)
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic                  ARP_EN,
  input  logic [15:0]           ARP_TIME,
  input  logic                  PINGPONGEN,
  input  logic [NUM_VOICES-1:0] KEY_IN,
  output logic [NUM_VOICES-1:0] KEY_OUT,
  output logic [IW-1:0]         STEP_IDX,
  output logic                  STEP_STROBE,
  output logic                  ARP_ACTIVE
);
  localparam int PW = TICK_DIV > 1 ? $clog2(TICK_DIV) : 1;
  state_e                state_q, state_d;
  dir_e                  dir_q, dir_d, sel_dir;
  logic [IW-1:0]         cur_q, cur_d, sel_nxt, lo_idx;
  logic                  sel_found, tick, advance;
  logic [PW-1:0]         presc_q, presc_d;
  logic [15:0]           cnt_q, cnt_d, step_lim;
  logic [NUM_VOICES-1:0] key_q, key_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic                  stb_q, stb_d, act_q, act_d;
  arp_next_sel #(.NV(NUM_VOICES), .IW(IW)) u_sel (
    .held_i    (KEY_IN),
    .cur_i     (cur_q),
    .dir_i     (dir_q),
    .pingpong_i(PINGPONGEN),
    .nxt_o     (sel_nxt),
    .dir_o     (sel_dir),
    .found_o   (sel_found)
  );
  always_comb begin
    lo_idx = '0;
    for (int i = NUM_VOICES - 1; i >= 0; i--) if (KEY_IN[i]) lo_idx = IW'(i);
    step_lim = ARP_TIME == 16'd0 ? 16'd1 : ARP_TIME;
    tick     = state_q == PLAY && presc_q == PW'(TICK_DIV - 1);
    // Compare against the live limit so a lowered ARP_TIME ends the step on the next tick.
    advance  = tick && (17'(cnt_q) + 17'd1 >= 17'(step_lim));
    presc_d  = (state_q != PLAY || tick) ? '0 : presc_q + 1'b1;
    cnt_d    = state_q != PLAY ? '0 : cnt_q + 16'(tick);
    state_d  = state_q;
    cur_d    = cur_q;
    dir_d    = dir_q;
    case (state_q)
      IDLE: if (ARP_EN && |KEY_IN) begin
        state_d = GAP;
        cur_d   = lo_idx;
        dir_d   = UP;
      end
      GAP: state_d = (ARP_EN && |KEY_IN) ? PLAY : IDLE;
      PLAY: if (!ARP_EN || !sel_found) state_d = IDLE;
        else if (!KEY_IN[cur_q] || advance) begin
          state_d = GAP;
          cur_d   = sel_nxt;
          dir_d   = sel_dir;
        end
      default: state_d = IDLE;
    endcase
    if (!PINGPONGEN) dir_d = UP;
    key_d = state_d == PLAY ? NUM_VOICES'(1) << cur_d : state_d == GAP ? '0 : KEY_IN;
    idx_d = state_d == PLAY ? cur_d : idx_q;
    stb_d = state_d == PLAY && state_q != PLAY;
    act_d = state_d != IDLE;
  end
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q <= IDLE;
      dir_q   <= UP;
      cur_q   <= '0;
      presc_q <= '0;
      cnt_q   <= '0;
      key_q   <= '0;
      idx_q   <= '0;
      stb_q   <= 1'b0;
      act_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      dir_q   <= dir_d;
      cur_q   <= cur_d;
      presc_q <= presc_d;
      cnt_q   <= cnt_d;
      key_q   <= key_d;
      idx_q   <= idx_d;
      stb_q   <= stb_d;
      act_q   <= act_d;
    end
  end
  assign KEY_OUT     = key_q;
  assign STEP_IDX    = idx_q;
  assign STEP_STROBE = stb_q;
  assign ARP_ACTIVE  = act_q;
endmodule

// File: tb/tb_arp_scheduler.sv
// tb_arp_scheduler: directed scenarios; expected per-cycle outputs are queued by the
// stimulus and checked by an independent monitor on the falling edge.
module tb_arp_scheduler;
  logic        CLK = 1'b0, RESET = 1'b1, ARP_EN = 1'b0, PINGPONGEN = 1'b0;
  logic [15:0] ARP_TIME = 16'd0;
  logic [7:0]  KEY_IN = 8'h00, KEY_OUT;
  logic [2:0]  STEP_IDX;
  logic        STEP_STROBE, ARP_ACTIVE;
  int          cyc = 0, vectors = 0, miscompares = 0;
  typedef struct {
    int          cyc;
    logic [12:0] v;
    string       tag;
  } exp_t;
  exp_t q[$];
  exp_t m;
  int up_seq[3] = '{1, 4, 6};
  int pp_seq[6] = '{1, 4, 6, 4, 1, 4};
  arp_scheduler #(.NUM_VOICES(8), .TICK_DIV(4)) dut (
    .CLK        (CLK),
    .RESET      (RESET),
    .ARP_EN     (ARP_EN),
    .ARP_TIME   (ARP_TIME),
    .PINGPONGEN (PINGPONGEN),
    .KEY_IN     (KEY_IN),
    .KEY_OUT    (KEY_OUT),
    .STEP_IDX   (STEP_IDX),
    .STEP_STROBE(STEP_STROBE),
    .ARP_ACTIVE (ARP_ACTIVE)
  );
  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;
  function automatic logic [12:0] obs();
    return {KEY_OUT, STEP_IDX, STEP_STROBE, ARP_ACTIVE};
  endfunction
  task automatic chk(input string tag, input logic [12:0] got, input logic [12:0] want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s @cyc %0d: got ko=%02h idx=%0d stb=%b act=%b, want ko=%02h idx=%0d stb=%b act=%b",
               tag, cyc, got[12:5], got[4:2], got[1], got[0], want[12:5], want[4:2], want[1], want[0]);
    end
  endtask
  always @(negedge CLK) begin
    while (q.size() > 0 && q[0].cyc <= cyc) begin
      m = q.pop_front();
      if (m.cyc < cyc) begin
        vectors++;
        miscompares++;
        $display("FAIL %s: sample for cycle %0d missed at cycle %0d", m.tag, m.cyc, cyc);
      end else chk(m.tag, obs(), m.v);
    end
  end
  task automatic ex(input logic [7:0] ko, input int idx, input bit stb, input bit act, input string tag);
    exp_t e;
    e.cyc = cyc + 1;
    e.v   = {ko, 3'(idx), stb, act};
    e.tag = tag;
    q.push_back(e);
    @(posedge CLK);
    #1;
  endtask
  task automatic run_step(input int v, input int n, input string tag);
    ex(8'(1 << v), v, 1'b1, 1'b1, tag);
    repeat (n - 1) ex(8'(1 << v), v, 1'b0, 1'b1, tag);
    ex(8'h00, v, 1'b0, 1'b1, {tag, "_gap"});
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
  initial begin
    @(posedge CLK);
    #1;
    chk("reset", obs(), 13'h0);
    RESET = 1'b0;
    KEY_IN = 8'h25; ex(8'h25, 0, 0, 0, "pass_25");
    KEY_IN = 8'h00; ex(8'h00, 0, 0, 0, "pass_00");
    KEY_IN = 8'hff; ex(8'hff, 0, 0, 0, "pass_ff");
    KEY_IN = 8'h00; ex(8'h00, 0, 0, 0, "pass_00b");
    ARP_EN = 1'b1; ARP_TIME = 16'd2; KEY_IN = 8'h52;
    ex(8'h00, 0, 0, 1, "up_gap0");
    foreach (up_seq[i]) run_step(up_seq[i], 8, "up");
    ex(8'h02, 1, 1, 1, "up_wrap");
    ARP_EN = 1'b0; ex(8'h52, 1, 0, 0, "en_off_pass");
    KEY_IN = 8'h00; ex(8'h00, 1, 0, 0, "idle_clr");
    ARP_EN = 1'b1; PINGPONGEN = 1'b1; KEY_IN = 8'h52;
    ex(8'h00, 1, 0, 1, "pp_gap0");
    foreach (pp_seq[i]) run_step(pp_seq[i], 8, "pp");
    ex(8'h40, 6, 1, 1, "pp_6");
    ARP_EN = 1'b0; KEY_IN = 8'h00; ex(8'h00, 6, 0, 0, "pp_off");
    ARP_EN = 1'b1; PINGPONGEN = 1'b0; ARP_TIME = 16'd0; KEY_IN = 8'h08;
    ex(8'h00, 6, 0, 1, "single_gap0");
    repeat (3) run_step(3, 4, "single");
    ex(8'h08, 3, 1, 1, "single_play");
    KEY_IN = 8'h00; ex(8'h00, 3, 0, 0, "keys_gone");
    ARP_TIME = 16'd2; KEY_IN = 8'h52;
    ex(8'h00, 3, 0, 1, "rel_gap0");
    run_step(1, 8, "rel_v1");
    ex(8'h10, 4, 1, 1, "rel_v4");
    ex(8'h10, 4, 0, 1, "rel_v4");
    ex(8'h10, 4, 0, 1, "rel_v4");
    KEY_IN = 8'h42; ex(8'h00, 4, 0, 1, "rel_gap");
    ex(8'h40, 6, 1, 1, "rel_v6");
    KEY_IN = 8'h00; ex(8'h00, 6, 0, 0, "rel_idle");
    KEY_IN = 8'h52;
    ex(8'h00, 6, 0, 1, "pre_rst_gap");
    ex(8'h02, 1, 1, 1, "pre_rst_play");
    ex(8'h02, 1, 0, 1, "pre_rst_play");
    @(negedge CLK);
    #2;
    RESET = 1'b1;
    #1;
    chk("async_reset", obs(), 13'h0);
    @(posedge CLK);
    #1;
    RESET = 1'b0; PINGPONGEN = 1'b1;
    ex(8'h00, 0, 0, 1, "restart_gap0");
    foreach (up_seq[i]) run_step(up_seq[i], 8, "restart");
    ex(8'h10, 4, 1, 1, "restart_pp_down");
    for (int i = 0; i < 20 && q.size() > 0; i++) @(negedge CLK);
    #1;
    if (q.size() > 0) begin
      vectors++;
      miscompares++;
      $display("FAIL drain: %0d expected samples never checked", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/arp_scheduler.md
Name: arp_scheduler

Overview:
- Sequences the 8 synth voice gates when the arpeggiator is enabled.
- Sits between the control register file outputs (KEY0..KEY7, ARP_EN, ARP_TIME, PINGPONGEN) and the voice/ADSR bank.
- ARP_EN=0: held keys pass straight through, registered.
- ARP_EN=1: exactly one held voice is gated at a time. The active voice steps every ARP_TIME ticks, in up or ping-pong order, with a 1-cycle gate gap at each step so the envelopes retrigger.

Parameters:
- NUM_VOICES, 8, number of voice gates; index width is clog2(NUM_VOICES).
- TICK_DIV, 50000, CLK cycles per ARP_TIME unit (1 ms at 50 MHz).

Ports:
- CLK  in  1  system clock
- RESET  in  1  reset
- ARP_EN  in  1  arpeggiator enable
- ARP_TIME  in  16  step length in ticks; 0 is treated as 1
- PINGPONGEN  in  1  1 = ping-pong order, 0 = ascending wrap order
- KEY_IN  in  NUM_VOICES  held-key vector, bit i = KEY_i
- KEY_OUT  out  NUM_VOICES  gate vector to the voice bank
- STEP_IDX  out  3  index of the currently gated voice
- STEP_STROBE  out  1  one-cycle pulse on the first PLAY cycle of each step
- ARP_ACTIVE  out  1  high while in GAP or PLAY

Behaviour:
- Clock and reset: one clock, CLK. RESET is asynchronous and active-high. In reset: state=IDLE, KEY_OUT=0, STEP_IDX=0, STEP_STROBE=0, ARP_ACTIVE=0, dir=up, prescaler=0, step_cnt=0.
- All outputs are registered.
- Tick: prescaler counts 0..TICK_DIV-1 while in PLAY; tick = wrap. step_cnt counts ticks. Both clear on entry to PLAY.
- step_lim = max(ARP_TIME,1), sampled live every cycle.
- State IDLE:
  - KEY_OUT <= KEY_IN (1-cycle latency).
  - If ARP_EN and |KEY_IN: go to GAP, cur = lowest held index, dir = up.
- State GAP (exactly 1 cycle):
  - KEY_OUT <= 0.
  - Next state is PLAY with the already-selected cur.
  - If KEY_IN==0 or !ARP_EN, go to IDLE instead.
- State PLAY:
  - KEY_OUT <= onehot(cur), STEP_IDX <= cur, ARP_ACTIVE=1.
  - STEP_STROBE=1 in the first PLAY cycle only.
- PLAY exit priority (highest first):
  1. !ARP_EN: go to IDLE; pass-through resumes next cycle.
  2. KEY_IN==0: go to IDLE, KEY_OUT <= 0.
  3. KEY_IN[cur]==0 (current key released): go to GAP immediately with next = sel(cur, dir).
  4. tick and step_cnt+1 >= step_lim: go to GAP with next = sel(cur, dir).
- Step period for a steady key set: step_lim*TICK_DIV cycles in PLAY, plus 1 GAP cycle.
- If ARP_TIME is lowered below the current step_cnt mid-step, advance on the next tick.
- Next-index selection sel(cur, dir) over held keys H:
  - Up mode (PINGPONGEN=0): smallest held index > cur; else wrap to smallest held index.
  - Ping-pong, dir=up: smallest held index > cur. If none, flip dir to down and take the largest held index < cur.
  - Ping-pong, dir=down: mirror of dir=up.
  - If no other held key exists, next = cur if held, else lowest held. The retrigger gap still occurs.
- PINGPONGEN may change at any time; dir is reset to up whenever PINGPONGEN=0.
- New keys pressed mid-run join the sequence at the next selection; the current step is not interrupted.

Decomposition:
- Package arp_pkg:
  - state enum {IDLE, GAP, PLAY};
  - NUM_VOICES default and index-width constant;
  - dir enum {UP, DOWN}.
- Sub-module arp_next_sel, purely combinational. Inputs: held vector, cur, dir, pingpong. Outputs: next index, next dir, found flag. It is instantiated once inside arp_scheduler.
- Prescaler, step counter and FSM stay in arp_scheduler.

Test Plan (TICK_DIV=4 in all scenarios):
- ARP_EN=0, KEY_IN=0x25 -> KEY_OUT=0x25 one cycle later. KEY_IN=0 -> KEY_OUT=0 one cycle later. STEP_STROBE never pulses.
- ARP_EN=1, ARP_TIME=2, PINGPONGEN=0, KEY_IN=0x52 (voices 1,4,6) -> KEY_OUT: 0x00 (GAP), 0x02 for 8 cycles, 0x00, 0x10 x8, 0x00, 0x40 x8, 0x00, 0x02, ... STEP_STROBE on the first cycle of each non-zero run; STEP_IDX=1,4,6,1.
- Same setup with PINGPONGEN=1 -> STEP_IDX sequence 1,4,6,4,1,4,6. Each step is 8 cycles plus a 1-cycle gap.
- Single key KEY_IN=0x08, ARP_TIME=0 -> KEY_OUT alternates 0x08 for 4 cycles, 0x00 for 1 cycle. STEP_IDX stays 3.
- While playing voice 4 (KEY_IN=0x52), drop KEY_IN to 0x42 at cycle 3 of the step -> next cycle KEY_OUT=0x00, then 0x40 with STEP_STROBE.
- Then set KEY_IN=0 -> IDLE, KEY_OUT=0, ARP_ACTIVE=0.
- Assert RESET asynchronously mid-PLAY (between clock edges) -> outputs go to 0 immediately, without waiting for CLK.
- After RESET release with ARP_EN=1, KEY_IN=0x52 -> sequence restarts at voice 1, dir=up.
